// File: rtl/shared_reg_arbiter.sv
// Purpose : round-robin arbiter writing one of N requesters into a shared register.
// Latency : 1 cycle from grant to out; a written value is held for at least HOLD cycles.
// Backpr. : no queueing; requests seen while busy are dropped, requesters hold req until granted.
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   req   [N]       - per-requester write request
//   in    [N*WIDTH] - requester i data at [i*WIDTH +: WIDTH]
//   grant [N]       - one-hot (or zero) combinational grant; write happens at this posedge
//   out   [WIDTH]   - shared register value
//   valid           - a write has happened since reset
//   busy            - current value still inside its hold window, no grant possible
module shared_reg_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int HOLD  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   in,
  output logic [N-1:0]         grant,
  output logic [WIDTH-1:0]     out,
  output logic                 valid,
  output logic                 busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [PW-1:0] g_idx;
  logic          found;

  assign busy = (cnt != '0);

  // Search ptr, ptr+1, ... modulo N and grant the first requester found.
  always_comb begin : grant_search
    logic [PW:0] sum;
    logic [PW-1:0] idx;
    grant = '0;
    g_idx = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    if (!reset && !busy) begin
      for (int k = 0; k < N; k++) begin
        sum = {1'b0, ptr} + (PW+1)'(k);
        if (sum >= (PW+1)'(N)) begin
          sum = sum - (PW+1)'(N);
        end
        idx = sum[PW-1:0];
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          g_idx      = idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out   <= '0;
      valid <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else if (found) begin
      out   <= in[g_idx*WIDTH +: WIDTH];
      valid <= 1'b1;
      ptr   <= (g_idx == PW'(N-1)) ? '0 : g_idx + 1'b1;
      // HOLD-1 further cycles of protection after the one in which the value lands.
      cnt   <= CW'(HOLD-1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Purpose : directed self-checking bench for shared_reg_arbiter (HOLD=3 and HOLD=1 instances).
// Latency : inputs driven and outputs sampled on the falling edge, away from the write edge.
// Backpr. : n/a.
module tb_shared_reg_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req1;
  logic [N*W-1:0] in;
  logic [N-1:0]   grant, grant1;
  logic [W-1:0]   out, out1;
  logic           valid, valid1, busy, busy1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] data [N];

  always #5 clk = ~clk;

  shared_reg_arbiter #(.WIDTH(W), .N(N), .HOLD(3)) dut (
    .clk(clk), .reset(reset), .req(req), .in(in),
    .grant(grant), .out(out), .valid(valid), .busy(busy)
  );

  shared_reg_arbiter #(.WIDTH(W), .N(N), .HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .in(in),
    .grant(grant1), .out(out1), .valid(valid1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle: past the write edge to the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'hA5; data[3] = 8'h44;
    in    = {data[3], data[2], data[1], data[0]};
    reset = 1'b1;
    req   = '0;
    req1  = '0;
    @(negedge clk);
    tick();

    // No grant while reset is high, even with every request set.
    req = 4'b1111;
    #1 check("grant_in_reset", grant, 4'b0000);
    tick();

    // Reset state.
    reset = 1'b0;
    req   = 4'b0000;
    #1;
    check("rst_out",   out,   8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst_grant", grant, 4'b0000);

    // Single request from requester 2.
    req = 4'b0100;
    #1 check("single_grant", grant, 4'b0100);
    tick();
    req = 4'b0000;
    #1;
    check("single_out",   out,   8'hA5);
    check("single_valid", valid, 1'b1);
    check("single_busy1", busy,  1'b1);
    tick();
    #1 check("single_busy2", busy, 1'b1);
    tick();
    #1 check("single_busy3", busy, 1'b0);

    // Pointer is now 3; requester 0 wins via wrap-around, then drops during hold.
    req = 4'b0001;
    #1 check("wrap_grant", grant, 4'b0001);
    tick();
    req = 4'b0010;
    #1;
    check("drop_grant1", grant, 4'b0000);
    check("drop_out1",   out,   8'h11);
    tick();
    #1;
    check("drop_grant2", grant, 4'b0000);
    check("drop_busy2",  busy,  1'b1);
    tick();
    req = 4'b0000;
    #1 check("drop_out3", out, 8'h11);
    tick();
    #1 check("drop_out4", out, 8'h11);

    // Reset in the middle of a hold window (pointer is 1 here).
    req = 4'b0010;
    #1 check("mid_grant", grant, 4'b0010);
    tick();
    reset = 1'b1;
    req   = 4'b0000;
    #1 check("mid_busy_before", busy, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    check("mid_out",   out,   8'h00);
    check("mid_valid", valid, 1'b0);
    check("mid_busy",  busy,  1'b0);

    // Round-robin with all requests held; HOLD=1 instance runs back-to-back alongside.
    req  = 4'b1111;
    req1 = 4'b1010;
    for (int k = 0; k <= 12; k++) begin
      logic [N-1:0] exp_g;
      logic [N-1:0] exp_g1;
      #1;
      exp_g  = (k % 3 == 0) ? (4'b0001 << ((k / 3) % 4)) : 4'b0000;
      exp_g1 = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      check($sformatf("rr_grant_%0d", k), grant, exp_g);
      if (k % 3 == 1) begin
        check($sformatf("rr_out_%0d", k), out, data[(k / 3) % 4]);
      end
      check($sformatf("h1_grant_%0d", k), grant1, exp_g1);
      check($sformatf("h1_busy_%0d", k), busy1, 1'b0);
      if (k >= 1) begin
        check($sformatf("h1_out_%0d", k), out1, (k % 2 == 1) ? data[1] : data[3]);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width of each requester and of the shared register.
REQ-002 The block SHALL have parameter N, default 4, meaning the number of requesters; legal range is N >= 2.
REQ-003 The block SHALL have parameter HOLD, default 1, meaning the minimum number of cycles a written value stays live before the next write; legal range is HOLD >= 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, N bits: bit i set means requester i wants to write.
REQ-007 The block SHALL have port in, input, N*WIDTH bits: requester i data occupies bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port grant, output, N bits: one-hot or zero; bit i means requester i's data is written at this posedge.
REQ-009 The block SHALL have port out, output, WIDTH bits: the current shared register value.
REQ-010 The block SHALL have port valid, output, 1 bit: set once any write has occurred since reset.
REQ-011 The block SHALL have port busy, output, 1 bit: high while the current value is within its HOLD window and no grant may issue.

Function
REQ-012 State SHALL consist of the data register, valid flag, round-robin pointer ptr (range 0..N-1) and hold counter cnt (range 0..HOLD-1).
REQ-013 busy SHALL be combinational and equal to (cnt != 0).
REQ-014 grant SHALL be combinational: zero when reset, busy or req == 0; otherwise one-hot at the first set req bit found searching ptr, ptr+1, ... modulo N.
REQ-015 On a posedge with grant[g] set, the block SHALL load out <= in[g], valid <= 1, ptr <= (g+1) mod N, and cnt <= HOLD-1.
REQ-016 On a posedge with cnt != 0 and not reset, cnt SHALL decrement by 1; out, valid and ptr SHALL hold.
REQ-017 On a posedge with no grant and cnt == 0, all state SHALL hold, so out retains the last written value indefinitely.
REQ-018 Write latency SHALL be 1: data granted in cycle t appears on out in cycle t+1 and is guaranteed stable through cycle t+HOLD.
REQ-019 With HOLD == 1, busy SHALL never assert, and grants may issue on consecutive cycles.
REQ-020 Requests asserted while busy SHALL be ignored and not queued; a requester must keep req high until it sees its grant bit.
REQ-021 The pointer SHALL advance only on a grant, so a requester with req held high is granted within N grant opportunities.
REQ-022 Deasserting req in the same cycle as a grant SHALL still complete that write.

Reset
REQ-023 When reset is high at a posedge, out SHALL become 0, valid 0, ptr 0 and cnt 0, regardless of any in-progress hold window.
REQ-024 While reset is high, grant SHALL be 0 and no write SHALL occur.
REQ-025 In the first cycle after reset deasserts, busy SHALL be 0 and a grant may issue.

Verification (N=4, WIDTH=8, HOLD=3 unless stated)
REQ-026 Reset check: after reset, out SHALL be 0x00, valid 0, busy 0, and grant 0000 with req=0000.
REQ-027 Single request: req=0100 and in[2]=0xA5 at cycle t -> grant=0100 at t; out=0xA5 and valid=1 at t+1; busy=1 at t+1 and t+2; busy=0 at t+3.
REQ-028 Round-robin: req=1111 held continuously -> grants 0001, 0010, 0100, 1000, 0001 at cycles t, t+3, t+6, t+9, t+12, with out equal to the granted requester's data one cycle after each grant.
REQ-029 Busy drop: req=0010 asserted only at t+1 and t+2 after a grant at t -> no grant; out unchanged through t+4.
REQ-030 Reset mid-hold: reset at t+1 after a grant at t -> at t+2 out=0x00, valid=0, busy=0; then req=1111 -> grant=0001.
REQ-031 HOLD=1 back-to-back: req=1010 held -> grants 0010, 1000, 0010 on consecutive cycles; busy never asserts.
